// File: rtl/seven_segment_scan_if.sv
// User-side bundle for seven_segment_scan: packed hex value, decimal points,
// load strobe, plus busy and frame status returned to the user logic.
interface seven_segment_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic                load;
    logic                busy;
    logic                frame;

    modport master (
        output value,
        output dp,
        output load,
        input  busy,
        input  frame
    );

    modport slave (
        input  value,
        input  dp,
        input  load,
        output busy,
        output frame
    );
endinterface : seven_segment_scan_if

// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit seven-segment scanner with tear-free frame-synchronous
// updates. Define SEVEN_SEGMENT_SCAN_LZB_EN to enable leading-zero blanking.
module seven_segment_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 1024,
    parameter int DEAD_CYCLES    = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rstn,
    seven_segment_scan_if.slave  bus,
    output logic [6:0]           seg,
    output logic                 seg_dp,
    output logic [DIGITS-1:0]    an
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITS-1:0]    pend_val_q, pend_val_d;
    logic [DIGITS-1:0]      pend_dp_q, pend_dp_d;
    logic [4*DIGITS-1:0]    disp_val_q, disp_val_d;
    logic [DIGITS-1:0]      disp_dp_q, disp_dp_d;
    logic                   busy_q, busy_d;
    logic                   frame_q, frame_d;
    logic [6:0]             seg_q, seg_d;
    logic                   seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]      an_q, an_d;

    logic                   tick;
    logic                   wrap;
    logic                   dead;
    logic [3:0]             cur_nib;
    logic                   cur_dp;
    logic                   cur_blank;
    logic [DIGITS-1:0]      blank;

    assign tick = (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);
    assign dead = (cnt_q < DEAD_END);

    // Prescaler, scan index and the pending/display handshake.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        busy_d     = busy_q;
        frame_d    = wrap;

        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp;
            busy_d     = 1'b1;
        end

        // A load coinciding with the wrap bypasses pending so it lands this frame.
        if (wrap) begin
            disp_val_d = bus.load ? bus.value : pend_val_q;
            disp_dp_d  = bus.load ? bus.dp    : pend_dp_q;
            busy_d     = 1'b0;
        end
    end

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    // Walk from the most-significant digit down, tracking "all zero so far".
    always_comb begin
        logic zeros_above;
        zeros_above = 1'b1;
        blank       = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zeros_above = zeros_above && (disp_val_q[4*k +: 4] == 4'h0);
            blank[k]    = zeros_above && !disp_dp_q[k];
        end
    end
`else
    assign blank = '0;
`endif

    // Digit selection, decode, dead time and polarity for the output registers.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        an_d      = AN_OFF;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dp    = disp_dp_q[k];
                cur_blank = blank[k];
                an_d[k]   = dead ? AN_ACTIVE_LOW : !AN_ACTIVE_LOW;
            end
        end
        seg_d    = (cur_blank ? 7'h00 : decode_hex(cur_nib)) ^ SEG_OFF;
        seg_dp_d = cur_dp ^ SEG_ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            busy_q     <= 1'b0;
            frame_q    <= 1'b0;
            seg_q      <= SEG_OFF;
            seg_dp_q   <= SEG_ACTIVE_LOW;
            an_q       <= AN_OFF;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            busy_q     <= busy_d;
            frame_q    <= frame_d;
            seg_q      <= seg_d;
            seg_dp_q   <= seg_dp_d;
            an_q       <= an_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.frame = frame_q;
    assign seg       = seg_q;
    assign seg_dp    = seg_dp_q;
    assign an        = an_q;

endmodule : seven_segment_scan

// File: tb/tb_seven_segment_scan.sv
// Directed self-checking bench for seven_segment_scan (4 digits, 4 clocks/slot,
// 1 dead cycle, active-low pins); blanking expectations follow SEVEN_SEGMENT_SCAN_LZB_EN.
module tb_seven_segment_scan;

    localparam int DIGITS      = 4;
    localparam int CLK_DIV     = 4;
    localparam int DEAD_CYCLES = 1;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;

    logic [6:0]  cap_seg   [16];
    logic        cap_dp    [16];
    logic [3:0]  cap_an    [16];
    logic        cap_frame [16];

    seven_segment_scan_if #(.DIGITS(DIGITS)) bus ();

    seven_segment_scan #(
        .DIGITS        (DIGITS),
        .CLK_DIV       (CLK_DIV),
        .DEAD_CYCLES   (DEAD_CYCLES),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .bus   (bus.slave),
        .seg   (seg),
        .seg_dp(seg_dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    // Sample i (0-based) after a frame boundary: slot i/4, first clock of each slot is dead.
    function automatic logic [3:0] exp_an(input int i);
        logic [3:0] one_hot;
        if (i % 4 == 0) return 4'hF;
        one_hot = 4'b0001 << (i / 4);
        return ~one_hot;
    endfunction

    // Records the 16 negedge samples that follow the current negedge.
    task automatic capture_frame();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cap_seg[i]   = seg;
            cap_dp[i]    = seg_dp;
            cap_an[i]    = an;
            cap_frame[i] = bus.frame;
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v;
        bus.dp    = d;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic test_reset();
        bus.value = '0;
        bus.dp    = '0;
        bus.load  = 1'b0;
        rstn      = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        do_load(16'h1234, 4'hF);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL reset_pre_busy: got %b want 1", bus.busy);
        end
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (seg !== 7'h7F) begin
            failures++; $display("FAIL reset_seg: got %h want 7f", seg);
        end
        checks++;
        if (seg_dp !== 1'b1) begin
            failures++; $display("FAIL reset_seg_dp: got %b want 1", seg_dp);
        end
        checks++;
        if (an !== 4'hF) begin
            failures++; $display("FAIL reset_an: got %h want f", an);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        checks++;
        if (bus.frame !== 1'b0) begin
            failures++; $display("FAIL reset_frame: got %b want 0", bus.frame);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Starts at the negedge where reset is released; ends on a frame negedge.
    task automatic test_scan_order();
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_an[i] !== exp_an(i)) begin
                    failures++; $display("FAIL scan_an f%0d s%0d: got %h want %h", f, i, cap_an[i], exp_an(i));
                end
                checks++;
                if (cap_frame[i] !== (i == 15)) begin
                    failures++; $display("FAIL scan_frame f%0d s%0d: got %b want %b", f, i, cap_frame[i], (i == 15));
                end
                checks++;
                if (cap_seg[i] !== 7'h40 || cap_dp[i] !== 1'b1) begin
                    failures++; $display("FAIL scan_seg f%0d s%0d: got %h/%b want 40/1", f, i, cap_seg[i], cap_dp[i]);
                end
            end
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL scan_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_tear_free();
        logic [6:0] exp_seg [4];
        logic [3:0] dp_in;
        bit         seen;
        exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        dp_in   = 4'b0101;
        repeat (5) @(negedge clk);
        do_load(16'h12AF, dp_in);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL tear_busy_set: got %b want 1", bus.busy);
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = bus.frame;
            checks++;
            if (bus.busy !== !seen) begin
                failures++; $display("FAIL tear_busy n%0d: got %b want %b", n, bus.busy, !seen);
            end
            checks++;
            if (seg !== 7'h40) begin
                failures++; $display("FAIL tear_old_seg n%0d: got %h want 40", n, seg);
            end
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL tear_frame_timeout: got 0 want 1");
        end
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i/4] || cap_dp[i] !== !dp_in[i/4] || cap_an[i] !== exp_an(i)) begin
                failures++;
                $display("FAIL tear_new s%0d: got %h/%b/%h want %h/%b/%h", i, cap_seg[i], cap_dp[i], cap_an[i],
                         exp_seg[i/4], !dp_in[i/4], exp_an(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL b2b_busy: got %b want 1", bus.busy);
        end
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = bus.frame;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL b2b_frame_timeout: got 0 want 1");
        end
        for (int f = 0; f < 2; f++) begin
            capture_frame();
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_seg[i] !== 7'h24 || cap_dp[i] !== 1'b1) begin
                    failures++; $display("FAIL b2b_seg f%0d s%0d: got %h/%b want 24/1", f, i, cap_seg[i], cap_dp[i]);
                end
            end
        end
    endtask

    // Entered on a frame negedge, so the next wrap edge is 16 clocks away.
    task automatic test_load_on_wrap();
        logic [6:0] exp_seg [4];
        exp_seg = '{7'h00, 7'h40, 7'h40, 7'h40};
        repeat (15) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL wrap_pre_busy: got %b want 0", bus.busy);
        end
        do_load(16'h0008, 4'h0);
        checks++;
        if (bus.frame !== 1'b1) begin
            failures++; $display("FAIL wrap_frame: got %b want 1", bus.frame);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL wrap_busy: got %b want 0", bus.busy);
        end
        capture_frame();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cap_seg[i] !== exp_seg[i/4] || cap_an[i] !== exp_an(i)) begin
                failures++;
                $display("FAIL wrap_seg s%0d: got %h/%h want %h/%h", i, cap_seg[i], cap_an[i], exp_seg[i/4], exp_an(i));
            end
            checks++;
            if (cap_frame[i] !== (i == 15)) begin
                failures++; $display("FAIL wrap_period s%0d: got %b want %b", i, cap_frame[i], (i == 15));
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] exp_seg [4];
        logic [3:0] dp_set [2];
        bit         seen;
        dp_set = '{4'b0000, 4'b0100};
        for (int p = 0; p < 2; p++) begin
`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
            exp_seg = '{7'h40, 7'h12, (p == 1) ? 7'h40 : 7'h7F, 7'h7F};
`else
            exp_seg = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif
            repeat (2) @(negedge clk);
            do_load(16'h0050, dp_set[p]);
            seen = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                seen = bus.frame;
            end
            checks++;
            if (!seen) begin
                failures++; $display("FAIL blank_frame_timeout p%0d: got 0 want 1", p);
            end
            capture_frame();
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap_seg[i] !== exp_seg[i/4] || cap_dp[i] !== !dp_set[p][i/4] || cap_an[i] !== exp_an(i)) begin
                    failures++;
                    $display("FAIL blank p%0d s%0d: got %h/%b/%h want %h/%b/%h", p, i, cap_seg[i], cap_dp[i],
                             cap_an[i], exp_seg[i/4], !dp_set[p][i/4], exp_an(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_tear_free();
        test_back_to_back();
        test_load_on_wrap();
        test_blanking();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule : tb_seven_segment_scan
